// File: rtl/fp_pkg.sv
// Shared FPU definitions: operand classification and integer-range helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        OP_NORMAL = 2'b00,
        OP_NAN    = 2'b01,
        OP_PINF   = 2'b10,
        OP_NINF   = 2'b11
    } opType_t;

    function automatic int fpBias(input int expWidth);
        return (1 << (expWidth - 1)) - 1;
    endfunction

    function automatic logic [63:0] intMax(input int logWidth);
        return (64'd1 << ((1 << logWidth) - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] intMin(input int logWidth);
        return 64'd1 << ((1 << logWidth) - 1);
    endfunction

endpackage

// File: rtl/fp_to_int_pipelined_if.sv
// Operand/result bundle between the FPU issue logic and the float-to-int converter.
interface fp_to_int_pipelined_if #(
    parameter int LOGWIDTH = 5
);
    localparam int W = 2**LOGWIDTH;

    logic [W-1:0] diA;
    logic         ciValid;
    logic         ciTrunc;
    logic         ciStallA;
    logic [W-1:0] doY;
    logic         coValid;
    logic         coInvalid;
    logic         coInexact;

    modport master (
        output diA, ciValid, ciTrunc, ciStallA,
        input  doY, coValid, coInvalid, coInexact
    );

    modport slave (
        input  diA, ciValid, ciTrunc, ciStallA,
        output doY, coValid, coInvalid, coInexact
    );
endinterface

// File: rtl/PipelineReg.sv
// Generic enabled pipeline register with asynchronous active-high clear.
module PipelineReg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             ci_rst,
    input  logic             ciEn,
    input  logic [WIDTH-1:0] diD,
    output logic [WIDTH-1:0] doQ
);
    always_ff @(posedge clk or posedge ci_rst) begin
        if (ci_rst)
            doQ <= '0;
        else if (ciEn)
            doQ <= diD;
    end
endmodule

// File: rtl/fpc_align.sv
// Combinational aligner: places the significand at its integer weight and
// extracts the guard bit and sticky OR of everything below it.
module fpc_align #(
    parameter int LOGWIDTH  = 5,
    parameter int EXPWIDTH  = 8,
    parameter int MANTWIDTH = 23
) (
    input  logic [MANTWIDTH:0]        diM,
    input  logic signed [EXPWIDTH:0]  diE,
    output logic [2**LOGWIDTH-1:0]    doMag,
    output logic                      doGuard,
    output logic                      doSticky,
    output logic                      doOvf
);
    localparam int W = 2**LOGWIDTH;
    localparam logic signed [EXPWIDTH:0] E_MAX  = (EXPWIDTH+1)'(W - 1);
    localparam logic signed [EXPWIDTH:0] E_NEG1 = '1;

    // Fixed point with W integer and W fraction bits; the leading 1 sits at bit W.
    logic [2*W-1:0] fixedM;
    logic [2*W-1:0] shifted;

    assign fixedM  = {{(W-1){1'b0}}, diM, {(W-MANTWIDTH){1'b0}}};
    assign shifted = fixedM << diE[LOGWIDTH-1:0];

    always_comb begin
        doOvf = diE > E_MAX;
        if (diE[EXPWIDTH]) begin
            doMag    = '0;
            doGuard  = (diE == E_NEG1);
            doSticky = (diE != E_NEG1) | (|diM[MANTWIDTH-1:0]);
        end else begin
            doMag    = shifted[2*W-1:W];
            doGuard  = shifted[W-1];
            doSticky = |shifted[W-2:0];
        end
    end
endmodule

// File: rtl/fp_to_int_pipelined.sv
// Two-stage IEEE-754 to two's-complement integer converter (truncate or RNE).
module fp_to_int_pipelined
    import fp_pkg::*;
#(
    parameter int LOGWIDTH  = 5,
    parameter int EXPWIDTH  = 8,
    parameter int MANTWIDTH = 23
) (
    input  logic                  clk,
    input  logic                  ci_rst,
    fp_to_int_pipelined_if.slave  bus
);
    localparam int W    = 2**LOGWIDTH;
    localparam int BIAS = fpBias(EXPWIDTH);
    localparam logic [W-1:0] INT_MAX = W'(intMax(LOGWIDTH));
    localparam logic [W-1:0] INT_MIN = W'(intMin(LOGWIDTH));

    if (W != EXPWIDTH + MANTWIDTH + 1) begin : g_badWidths
        $error("fp_to_int_pipelined: 2**LOGWIDTH must equal EXPWIDTH+MANTWIDTH+1");
    end

    typedef struct packed {
        logic         valid;
        logic         trunc;
        logic         sign;
        opType_t      op;
        logic         ovf;
        logic         guard;
        logic         sticky;
        logic [W-1:0] mag;
    } stageA_t;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] y;
        logic         invalid;
        logic         inexact;
    } stageB_t;

    logic                   sA;
    logic [EXPWIDTH-1:0]    expA;
    logic [MANTWIDTH-1:0]   fracA;
    logic signed [EXPWIDTH:0] eA;
    logic [W-1:0]           alMag;
    logic                   alGuard, alSticky, alOvf;
    stageA_t                aIn, aQ;
    stageB_t                bIn, bQ;

    assign {sA, expA, fracA} = bus.diA;
    assign eA = $signed({1'b0, expA}) - $signed((EXPWIDTH+1)'(BIAS));

    fpc_align #(
        .LOGWIDTH  (LOGWIDTH),
        .EXPWIDTH  (EXPWIDTH),
        .MANTWIDTH (MANTWIDTH)
    ) u_align (
        .diM      ({1'b1, fracA}),
        .diE      (eA),
        .doMag    (alMag),
        .doGuard  (alGuard),
        .doSticky (alSticky),
        .doOvf    (alOvf)
    );

    always_comb begin
        aIn        = '0;
        aIn.valid  = bus.ciValid;
        aIn.trunc  = bus.ciTrunc;
        aIn.sign   = sA;
        aIn.mag    = alMag;
        aIn.guard  = alGuard;
        aIn.sticky = alSticky;
        aIn.ovf    = alOvf;
        if (&expA)
            aIn.op = (|fracA) ? OP_NAN : (sA ? OP_NINF : OP_PINF);
        else
            aIn.op = OP_NORMAL;
        // Denormals flush to zero; sticky alone carries the inexact flag, so no rounding up.
        if (expA == '0) begin
            aIn.mag    = '0;
            aIn.guard  = 1'b0;
            aIn.sticky = |fracA;
            aIn.ovf    = 1'b0;
        end
    end

    PipelineReg #(.WIDTH($bits(stageA_t))) u_pr1 (
        .clk    (clk),
        .ci_rst (ci_rst),
        .ciEn   (!bus.ciStallA),
        .diD    (aIn),
        .doQ    (aQ)
    );

    logic [W:0] magR;
    logic       incB, rangeOvf, invB;

    always_comb begin
        incB = !aQ.trunc & aQ.guard & (aQ.sticky | aQ.mag[0]);
        magR = {1'b0, aQ.mag} + (W+1)'(incB);
        // Negative side allows exactly 2**(W-1); positive side stops one short.
        rangeOvf = aQ.sign ? (magR[W] | (magR[W-1] & (|magR[W-2:0])))
                           : (magR[W] | magR[W-1]);
        invB = aQ.ovf | (aQ.op != OP_NORMAL) | rangeOvf;

        bIn         = '0;
        bIn.valid   = aQ.valid & !bus.ciStallA;
        bIn.invalid = invB;
        bIn.inexact = !invB & (aQ.guard | aQ.sticky);
        if (invB)
            bIn.y = (aQ.op == OP_NAN || !aQ.sign) ? INT_MAX : INT_MIN;
        else
            bIn.y = aQ.sign ? -magR[W-1:0] : magR[W-1:0];
    end

    PipelineReg #(.WIDTH($bits(stageB_t))) u_pr2 (
        .clk    (clk),
        .ci_rst (ci_rst),
        .ciEn   (1'b1),
        .diD    (bIn),
        .doQ    (bQ)
    );

    assign bus.doY       = bQ.y;
    assign bus.coValid   = bQ.valid;
    assign bus.coInvalid = bQ.invalid;
    assign bus.coInexact = bQ.inexact;
endmodule

// File: tb/tb_fp_to_int_pipelined.sv
// Directed and random checks of the float-to-int converter against a hand model.
module tb_fp_to_int_pipelined;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fp_to_int_pipelined_if #(.LOGWIDTH(5)) bus();

    fp_to_int_pipelined #(
        .LOGWIDTH  (5),
        .EXPWIDTH  (8),
        .MANTWIDTH (23)
    ) dut (
        .clk    (clk),
        .ci_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Independent model: integer division by a power of two with remainder/half compare.
    function automatic logic [33:0] refModel(input logic [31:0] w, input logic trunc);
        logic   s;
        int     ex, sh;
        longint m, mag, rem, half, val;
        logic   up;
        s  = w[31];
        ex = int'(w[30:23]);
        if (ex == 255) begin
            if (w[22:0] != 0 || !s) return {32'h7FFFFFFF, 2'b10};
            return {32'h80000000, 2'b10};
        end
        if (ex == 0) return {32'h0, 1'b0, (w[22:0] != 0)};
        ex = ex - 127;
        m  = longint'({1'b1, w[22:0]});
        if (ex > 31) return s ? {32'h80000000, 2'b10} : {32'h7FFFFFFF, 2'b10};
        if (ex >= 23) begin
            mag = m << (ex - 23); rem = 0; half = 1;
        end else if (ex >= -1) begin
            sh   = 23 - ex;
            mag  = m >>> sh;
            rem  = m & ((64'sd1 <<< sh) - 1);
            half = 64'sd1 <<< (sh - 1);
        end else begin
            mag = 0; rem = 1; half = 4;
        end
        up  = !trunc && (rem > half || (rem == half && mag[0]));
        mag = mag + (up ? 1 : 0);
        val = s ? -mag : mag;
        if (val > 64'sd2147483647)  return {32'h7FFFFFFF, 2'b10};
        if (val < -64'sd2147483648) return {32'h80000000, 2'b10};
        return {val[31:0], 1'b0, (rem != 0)};
    endfunction

    typedef struct {
        logic [31:0] w;
        logic        trunc;
        logic [31:0] y;
        logic        inv;
        logic        inex;
    } vec_t;

    vec_t vecs[$];

    task automatic issue(input logic [31:0] w, input logic trunc);
        @(negedge clk);
        bus.diA = w; bus.ciTrunc = trunc; bus.ciValid = 1'b1;
        @(negedge clk);
        bus.ciValid = 1'b0;
        @(negedge clk);
    endtask

    logic [33:0] expQ[$];
    logic [33:0] expE;
    logic [31:0] rw;
    logic        rt, rs;
    int          sent;

    initial begin
        rst = 1'b1;
        bus.diA = '0; bus.ciValid = 1'b0; bus.ciTrunc = 1'b0; bus.ciStallA = 1'b0;
        repeat (2) @(negedge clk);
        chkEq("rst_y",   bus.doY,       0);
        chkEq("rst_v",   bus.coValid,   0);
        chkEq("rst_inv", bus.coInvalid, 0);
        chkEq("rst_inx", bus.coInexact, 0);
        rst = 1'b0;

        vecs.push_back('{32'h3FC00000, 1'b1, 32'h00000001, 1'b0, 1'b1});
        vecs.push_back('{32'h3FC00000, 1'b0, 32'h00000002, 1'b0, 1'b1});
        vecs.push_back('{32'h40200000, 1'b0, 32'h00000002, 1'b0, 1'b1});
        vecs.push_back('{32'hBF000000, 1'b0, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{32'hCF000000, 1'b0, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{32'h4F000000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h4EFFFFFF, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0});
        vecs.push_back('{32'h7FC00000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'hFF800000, 1'b0, 32'h80000000, 1'b1, 1'b0});
        vecs.push_back('{32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{32'h3F800000, 1'b0, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{32'h40600000, 1'b0, 32'h00000004, 1'b0, 1'b1});
        vecs.push_back('{32'h40600000, 1'b1, 32'h00000003, 1'b0, 1'b1});
        vecs.push_back('{32'hBFC00000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1});
        vecs.push_back('{32'h7F800000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'hCF000001, 1'b0, 32'h80000000, 1'b1, 1'b0});
        vecs.push_back('{32'h3F000001, 1'b0, 32'h00000001, 1'b0, 1'b1});
        vecs.push_back('{32'h3E800000, 1'b0, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{32'hCEFFFFFF, 1'b0, 32'h80000080, 1'b0, 1'b0});
        vecs.push_back('{32'h53800000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].trunc);
            chkEq($sformatf("dir%0d_v", i), bus.coValid, 1);
            chkEq($sformatf("dir%0d_%h", i, vecs[i].w),
                  {bus.doY, bus.coInvalid, bus.coInexact},
                  {vecs[i].y, vecs[i].inv, vecs[i].inex});
        end

        // Stall while 2.0 sits in the first stage.
        @(negedge clk);
        bus.diA = 32'h3F800000; bus.ciTrunc = 1'b0; bus.ciValid = 1'b1;
        @(negedge clk);
        bus.diA = 32'h40000000;
        @(negedge clk);
        chkEq("stl_out1", {bus.coValid, bus.doY}, {1'b1, 32'd1});
        bus.ciStallA = 1'b1; bus.diA = 32'h40400000;
        @(negedge clk);
        chkEq("stl_bub1", bus.coValid, 0);
        @(negedge clk);
        chkEq("stl_bub2", bus.coValid, 0);
        bus.ciStallA = 1'b0;
        @(negedge clk);
        chkEq("stl_out2", {bus.coValid, bus.doY}, {1'b1, 32'd2});
        bus.ciValid = 1'b0;
        @(negedge clk);
        chkEq("stl_out3", {bus.coValid, bus.doY}, {1'b1, 32'd3});
        @(negedge clk);
        chkEq("stl_end", bus.coValid, 0);

        // Reset pulsed between edges with two ops in flight.
        @(negedge clk);
        bus.diA = 32'h40A00000; bus.ciValid = 1'b1;
        @(negedge clk);
        bus.diA = 32'h40C00000;
        @(negedge clk);
        bus.ciValid = 1'b0;
        chkEq("rmid_pre", {bus.coValid, bus.doY}, {1'b1, 32'd5});
        #1 rst = 1'b1;
        #1;
        chkEq("rmid_y", bus.doY,     0);
        chkEq("rmid_v", bus.coValid, 0);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chkEq("rmid_idle", bus.coValid, 0);
        end
        issue(32'h40E00000, 1'b0);
        chkEq("rmid_new", {bus.coValid, bus.doY}, {1'b1, 32'd7});

        // Random stream with occasional stalls, checked through a scoreboard.
        sent = 0;
        for (int cyc = 0; cyc < 13000; cyc++) begin
            @(negedge clk);
            if (bus.coValid) begin
                if (expQ.size() == 0) begin
                    chkEq("rnd_extra", bus.coValid, 0);
                end else begin
                    expE = expQ.pop_front();
                    chkEq("rnd", {bus.doY, bus.coInvalid, bus.coInexact}, expE);
                end
            end
            if (sent < 10000) begin
                rw = $urandom;
                if ($urandom_range(0, 1) == 1) rw[30:23] = 8'($urandom_range(100, 160));
                if ($urandom_range(0, 3) == 0) rw[15:0] = '0;
                rt = 1'($urandom_range(0, 1));
                rs = ($urandom_range(0, 9) == 0);
                bus.diA = rw; bus.ciTrunc = rt; bus.ciValid = 1'b1; bus.ciStallA = rs;
                if (!rs) begin
                    expQ.push_back(refModel(rw, rt));
                    sent++;
                end
            end else begin
                bus.ciValid = 1'b0; bus.ciStallA = 1'b0;
                if (expQ.size() == 0) break;
            end
        end
        chkEq("rnd_sent",  sent, 10000);
        chkEq("rnd_drain", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
